// File: rtl/nitta_to_spi_splitter.sv
// Splits a NITTA data word into SPI-sized chunks, MSB chunk first, advancing one
// chunk per rising edge of spi_ready and pulsing splitter_ready when the word is done.
module nitta_to_spi_splitter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ATTR_WIDTH     = 0,
  parameter int SPI_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_ready,
  output logic [SPI_DATA_WIDTH-1:0] to_spi,
  output logic                      splitter_ready,
  input  logic [DATA_WIDTH-1:0]     from_nitta
);

  localparam int N     = DATA_WIDTH / SPI_DATA_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  if ((ATTR_WIDTH != 0) || (DATA_WIDTH % SPI_DATA_WIDTH != 0)) begin : g_bad_cfg
    $error("nitta_to_spi_splitter: unsupported parameter combination");
  end

  logic [CNT_W-1:0]          r_idx;
  logic                      r_ready_d;
  logic                      w_rise;
  logic [CNT_W-1:0]          w_next_idx;
  logic [SPI_DATA_WIDTH-1:0] w_chunks [N];

  for (genvar k = 0; k < N; k++) begin : g_chunk
    assign w_chunks[k] = from_nitta[DATA_WIDTH-1-k*SPI_DATA_WIDTH -: SPI_DATA_WIDTH];
  end

  // Rise is gated by rst so nothing advances or pulses while reset is held.
  always_comb begin
    w_rise         = rst & spi_ready & ~r_ready_d;
    w_next_idx     = r_idx;
    splitter_ready = 1'b0;
    if (w_rise) begin
      w_next_idx     = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      splitter_ready = (r_idx == LAST_IDX);
    end
    to_spi = w_chunks[w_next_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx     <= '0;
      r_ready_d <= 1'b0;
    end else begin
      r_idx     <= w_next_idx;
      r_ready_d <= spi_ready;
    end
  end

endmodule

// File: tb/tb_nitta_to_spi_splitter.sv
// Directed plus randomized bench for nitta_to_spi_splitter, compared against a
// word-level model that counts advances since reset.
module tb_nitta_to_spi_splitter;

  localparam int DW = 32;
  localparam int SW = 8;
  localparam int N  = DW / SW;

  logic          clk = 1'b0;
  logic          rst;
  logic          spi_ready;
  logic [SW-1:0] to_spi;
  logic          splitter_ready;
  logic [DW-1:0] from_nitta;

  int total = 0;
  int bad   = 0;

  // Model state: advances accepted since the last reset, and last sampled spi_ready.
  int   m_adv  = 0;
  logic m_prev = 1'b0;

  nitta_to_spi_splitter #(
    .DATA_WIDTH(DW),
    .ATTR_WIDTH(0),
    .SPI_DATA_WIDTH(SW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .spi_ready     (spi_ready),
    .to_spi        (to_spi),
    .splitter_ready(splitter_ready),
    .from_nitta    (from_nitta)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] chunk_of(input logic [DW-1:0] w, input int k);
    logic [DW-1:0] sh;
    sh = w >> (SW * (N - 1 - k));
    return sh[SW-1:0];
  endfunction

  task automatic chk8(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: to_spi observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: splitter_ready observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive just after the edge, check 1 time unit later, then advance the model.
  task automatic cyc(input string tag, input logic r, input logic s, input logic [DW-1:0] d);
    logic rise;
    int   adv_now;
    @(posedge clk);
    #1;
    rst        = r;
    spi_ready  = s;
    from_nitta = d;
    #1;
    rise    = r && s && !m_prev;
    adv_now = r ? (m_adv + (rise ? 1 : 0)) : 0;
    chk8(tag, to_spi, chunk_of(d, adv_now % N));
    chk1(tag, splitter_ready, rise && (adv_now % N == 0));
    m_adv  = adv_now;
    m_prev = r ? s : 1'b0;
  endtask

  localparam logic [DW-1:0] WORD = 32'hA0B1C2D3;

  initial begin
    logic [DW-1:0] rd;
    logic          rr;
    logic          rs;
    rst        = 1'b1;
    spi_ready  = 1'b0;
    from_nitta = WORD;

    // Reset and idle; spi_ready high during reset must not advance or pulse.
    cyc("rst_hold", 1'b0, 1'b0, WORD);
    cyc("rst_spi_hi", 1'b0, 1'b1, WORD);
    cyc("rst_hold2", 1'b0, 1'b0, WORD);
    for (int i = 0; i < 3; i++) cyc("idle", 1'b1, 1'b0, WORD);

    // Single-cycle pulses with gaps, including a 3-cycle gap.
    cyc("pulse_b1", 1'b1, 1'b1, WORD);
    cyc("hold_b1", 1'b1, 1'b0, WORD);
    cyc("pulse_c2", 1'b1, 1'b1, WORD);
    for (int i = 0; i < 3; i++) cyc("hold_c2", 1'b1, 1'b0, WORD);
    cyc("pulse_d3", 1'b1, 1'b1, WORD);
    cyc("hold_d3", 1'b1, 1'b0, WORD);

    // Fourth pulse wraps to A0 with a one-cycle splitter_ready.
    cyc("wrap", 1'b1, 1'b1, WORD);
    cyc("after_wrap", 1'b1, 1'b0, WORD);

    // Held-high spi_ready right after reset release is a single advance.
    cyc("rst2", 1'b0, 1'b0, WORD);
    for (int i = 0; i < 4; i++) cyc("held_hi", 1'b1, 1'b1, WORD);
    for (int i = 0; i < 2; i++) cyc("held_lo", 1'b1, 1'b0, WORD);

    // Finish word (C2, D3) then hold high across the wrap edge.
    cyc("to_c2", 1'b1, 1'b1, WORD);
    cyc("gap", 1'b1, 1'b0, WORD);
    cyc("to_d3", 1'b1, 1'b1, WORD);
    cyc("gap", 1'b1, 1'b0, WORD);
    for (int i = 0; i < 3; i++) cyc("wrap_held", 1'b1, 1'b1, WORD);
    cyc("wrap_rel", 1'b1, 1'b0, WORD);

    // Live from_nitta change mid-word alters the shown chunk but not the index.
    cyc("adv_b", 1'b1, 1'b1, WORD);
    cyc("live_data", 1'b1, 1'b0, 32'h11223344);
    cyc("live_back", 1'b1, 1'b0, WORD);

    // Abort at C2 via reset, then resume from chunk 0.
    cyc("adv_c2", 1'b1, 1'b1, WORD);
    cyc("show_c2", 1'b1, 1'b0, WORD);
    cyc("abort", 1'b0, 1'b0, WORD);
    cyc("abort_rel", 1'b1, 1'b0, WORD);
    cyc("resume_b1", 1'b1, 1'b1, WORD);
    cyc("resume_hold", 1'b1, 1'b0, WORD);

    // Randomized traffic: occasional resets and data changes.
    rd = WORD;
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 59) != 0);
      rs = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) rd = $urandom();
      cyc("random", rr, rs, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
